fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 26 ++
 rtl/fetch_unit_queue.sv | 69 ++++++
 rtl/fetch_unit.sv | 99 +++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants for the fetch/decode front end: instruction geometry,
// opcode map and fetch state encodings.
package fetch_unit_pkg;

  localparam int OPCODE_W = 6;
  localparam int INSTR_W  = 32;

  // Opcode map (instr[31:26]) shared with decode.
  localparam logic [OPCODE_W-1:0] OP_NOP    = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_ALU    = 6'b000001;
  localparam logic [OPCODE_W-1:0] OP_JUMP   = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_HALT   = 6'b111111;

  // Fetch state encodings.
  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  // Extract the opcode field from an instruction word.
  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] w);
    return w[INSTR_W-1 -: OPCODE_W];
  endfunction

endpackage

// File: rtl/fetch_unit_queue.sv
// Two-entry in-order FIFO holding {pc, instruction} pairs between the
// instruction memory and decode. Flush wins over push and pop.
module fetch_queue #(
  parameter int W = 40
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] head,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         pop_ok, push_ok;

  assign empty   = (count_q == 2'd0);
  assign full    = (count_q == 2'd2);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  // Queue registers; storage clears on reset so the head reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues sequential reads to a 1-cycle instruction
// memory, buffers returned words in a 2-entry queue and hands them to decode.
// Handshake: a word transfers on a cycle where instr_valid & instr_ready;
// while instr_valid=1 and instr_ready=0 the instr/instr_pc outputs hold.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               halted
);

  localparam int QW = PC_W + INSTR_W;

  logic [0:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            inflight_q, inflight_d;
  logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;

  logic [QW-1:0]   q_head;
  logic [1:0]      q_count;
  logic            q_full, q_empty;
  logic            pop, push, halt_arrive;
  logic [2:0]      fill;

  assign pop  = ~q_empty & instr_ready;
  assign push = inflight_q & ~redirect_valid;
  assign halt_arrive = push & (opcode_of(imem_rdata) == OP_HALT);

  // Occupancy the queue will have after this edge, before counting a new
  // request; the concurrent dequeue is credited so fetch keeps one per cycle.
  assign fill = {1'b0, q_count} - {2'b0, pop} + {2'b0, inflight_q};

  // A returning HALT word suppresses the request that would follow it.
  assign imem_req = rst_n & (state_q == ST_RUN) & ~redirect_valid & ~halt_arrive
                  & ~(q_full & ~pop) & (fill < 3'd2);
  assign imem_addr = pc_q;

  fetch_queue #(.W(QW)) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({inflight_pc_q, imem_rdata}),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign instr_valid = ~q_empty;
  assign instr       = q_empty ? '0 : q_head[INSTR_W-1:0];
  assign instr_pc    = q_empty ? '0 : q_head[QW-1:INSTR_W];
  assign halted      = (state_q == ST_HALTED);

  // PC, in-flight tracking and RUN/HALTED transitions; redirect dominates.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = imem_req;
    inflight_pc_d = pc_q;
    if (redirect_valid) begin
      state_d = ST_RUN;
      pc_d    = redirect_pc;
    end else begin
      if (halt_arrive) state_d = ST_HALTED;
      if (imem_req)    pc_d    = pc_q + PC_W'(1);
    end
  end

  // Fetch control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

endmodule
